mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Load/store request and response handshake between a requester and the
// memory access controller. The requester is the master, the controller the slave.
interface mem_access_ctrl_if #(
  parameter int RAW = 8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [RAW-1:0]  req_addr;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_ready;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: an instruction fetch unit reading a combinational
// ROM, and an independent single-outstanding load/store engine driving a
// synchronous RAM whose read data appears the cycle after the strobe.
module mem_access_ctrl #(
  parameter int NUM_RAM_ADDRESS = 256,
  parameter int NUM_ROM_ADDRESS = 256,
  localparam int RAW = $clog2(NUM_RAM_ADDRESS),
  localparam int ROW = $clog2(NUM_ROM_ADDRESS)
) (
  input  logic                 clk,
  input  logic                 reset,
  // instruction fetch
  input  logic                 fetch_en,
  input  logic                 branch_valid,
  input  logic [ROW-1:0]       branch_target,
  output logic [ROW-1:0]       pc,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  // load/store handshake
  mem_access_ctrl_if.slave     bus,
  // memory side
  output logic [ROW-1:0]       rom_address,
  input  logic [31:0]          rom_out,
  output logic [RAW-1:0]       ram_address,
  output logic [31:0]          data_reg_to_mem,
  output logic                 ram_write,
  output logic                 ram_enable,
  input  logic [31:0]          ram_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            wr_q;
  logic [RAW-1:0]  addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rsp_rdata_q;
  logic            req_ready_c;
  logic            rsp_valid_c;
  logic [ROW-1:0]  pc_next;

  // The last ROM word wraps to zero explicitly so non-power-of-two depths work.
  assign pc_next     = (pc == ROW'(NUM_ROM_ADDRESS - 1)) ? '0 : pc + ROW'(1);
  assign rom_address = pc;

  // Fetch: a branch wins over a fetch and discards the word on the ROM bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (branch_valid) begin
      pc          <= branch_target;
      instr_valid <= 1'b0;
    end else if (fetch_en) begin
      instr       <= rom_out;
      instr_valid <= 1'b1;
      pc          <= pc_next;
    end else begin
      instr_valid <= 1'b0;
    end
  end

  // Load/store state register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake/strobe decode for the load/store engine.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    ram_enable  = 1'b0;
    ram_write   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        ram_enable = 1'b1;
        ram_write  = wr_q;
        state_next = wr_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch and response data; rsp_rdata only moves in ACCESS/CAPTURE so it is stable in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        ACCESS: begin
          if (wr_q) begin
            rsp_rdata_q <= '0;
          end
        end
        CAPTURE: begin
          rsp_rdata_q <= ram_out;
        end
        default: begin
        end
      endcase
    end
  end

  assign ram_address     = addr_q;
  assign data_reg_to_mem = wdata_q;
  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule
